// File: rtl/usb_tx_arb_defs.sv
// ----------------------------------------------------------------------------
// usb_tx_arb_defs
//   Shared definitions for the UTMI transmit arbiter: FSM state encodings,
//   one-hot grant codes and a counter-width helper.
// ----------------------------------------------------------------------------
package usb_tx_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_REQ0 = 2'b01;
  localparam logic [1:0] GRANT_REQ1 = 2'b10;

  // Bits needed to hold the value max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/usb_tx_timer.sv
// ----------------------------------------------------------------------------
// usb_tx_timer
//   Loadable up/down counter that saturates at both ends, with a zero flag.
//   Priority: clear > load > increment > decrement.
// Ports
//   clk, rst     clock, asynchronous active-low reset
//   i_clear      force count to zero
//   i_load       load i_load_val
//   i_inc        count up (holds at all-ones)
//   i_dec        count down (holds at zero)
//   o_count      current count
//   o_zero       count == 0
// ----------------------------------------------------------------------------
module usb_tx_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // NOTE: state is written only with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/usb_utmi_tx_arb.sv
// ----------------------------------------------------------------------------
// usb_utmi_tx_arb
//   Shares the UTMI transmit port between req0 (handshake/token engine, high
//   priority) and req1 (data-packet engine). Whole packets are sent without
//   interleaving, an inter-packet gap is enforced, a new packet is not
//   started while the PHY is receiving, and a packet is aborted on PHY stall
//   timeout, source underrun or USB bus reset.
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   usb_rst                       USB bus reset: abort and return to idle
//   reqN_valid/_data/_last        packet source N byte stream
//   reqN_ready                    byte accepted this clock (with reqN_valid)
//   utmi_data_out, utmi_tx_valid  to PHY DataOut/TxValid
//   utmi_tx_ready, utmi_rx_active from PHY TxReady/RxActive
//   grant                         one-hot packet owner, 00 when not sending
//   busy                          arbiter not idle
//   tx_done / tx_err              one-clock pulses: packet sent / aborted
// ----------------------------------------------------------------------------
module usb_utmi_tx_arb
  import usb_tx_arb_defs::*;
#(
  parameter int IPG_CYCLES    = 8,
  parameter int READY_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] utmi_data_out,
  output logic       utmi_tx_valid,
  input  logic       utmi_tx_ready,
  input  logic       utmi_rx_active,
  output logic [1:0] grant,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int GAP_W = cnt_width(IPG_CYCLES);
  localparam int TO_W  = cnt_width(READY_TIMEOUT);

  arb_state_e       r_state;
  logic [1:0]       r_grant;
  logic             r_tx_valid;
  logic             r_tx_done;
  logic             r_tx_err;

  logic             w_in_send;
  logic             w_own_valid;
  logic             w_own_last;
  logic             w_accept;
  logic             w_done;
  logic             w_timeout;
  logic             w_abort;
  logic             w_to_gap;
  logic             w_gap_zero;
  logic [TO_W-1:0]  w_to_cnt;
  logic [GAP_W-1:0] w_gap_cnt_unused;
  logic             w_to_zero_unused;

  assign w_in_send = (r_state == ST_SEND);

  assign req0_ready = r_grant[0] & utmi_tx_ready & w_in_send & r_tx_valid;
  assign req1_ready = r_grant[1] & utmi_tx_ready & w_in_send & r_tx_valid;

  // Byte stream of whichever source owns the current packet.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    utmi_data_out = 8'h00;
    w_own_valid   = 1'b0;
    w_own_last    = 1'b0;
    if (r_grant == GRANT_REQ0) begin
      utmi_data_out = req0_data;
      w_own_valid   = req0_valid;
      w_own_last    = req0_last;
    end else if (r_grant == GRANT_REQ1) begin
      utmi_data_out = req1_data;
      w_own_valid   = req1_valid;
      w_own_last    = req1_last;
    end
  end

  assign w_accept  = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_done    = w_in_send & w_accept & w_own_last;
  // The timer holds the number of stalled clocks already seen, so this clock
  // being stalled too makes READY_TIMEOUT in a row.
  assign w_timeout = w_in_send & ~utmi_tx_ready &
                     (w_to_cnt >= TO_W'(READY_TIMEOUT - 1));
  // A completed last byte beats a simultaneous underrun/timeout.
  assign w_abort   = ~w_done & ((w_in_send & ~w_own_valid) | w_timeout);
  assign w_to_gap  = ~usb_rst & (w_done | w_abort);

  usb_tx_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (1'b0),
    .i_load     (w_to_gap),
    .i_load_val (GAP_W'(IPG_CYCLES)),
    .i_inc      (1'b0),
    .i_dec      (r_state == ST_GAP),
    .o_count    (w_gap_cnt_unused),
    .o_zero     (w_gap_zero)
  );

  // Counts consecutive stalled SEND clocks; any TxReady or leaving SEND
  // restarts the run.
  usb_tx_timer #(.W(TO_W)) u_ready_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (~w_in_send | utmi_tx_ready),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_in_send),
    .i_dec      (1'b0),
    .o_count    (w_to_cnt),
    .o_zero     (w_to_zero_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= GRANT_NONE;
      r_tx_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      if (usb_rst) begin
        r_tx_err   <= w_in_send;
        r_state    <= ST_IDLE;
        r_grant    <= GRANT_NONE;
        r_tx_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!utmi_rx_active && (req0_valid || req1_valid)) begin
              r_grant    <= req0_valid ? GRANT_REQ0 : GRANT_REQ1;
              r_state    <= ST_SEND;
              r_tx_valid <= 1'b1;
            end
          end
          ST_SEND: begin
            if (w_done || w_abort) begin
              r_tx_done  <= w_done;
              r_tx_err   <= w_abort;
              r_grant    <= GRANT_NONE;
              r_tx_valid <= 1'b0;
              r_state    <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (w_gap_zero) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_grant    <= GRANT_NONE;
            r_tx_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign utmi_tx_valid = r_tx_valid;
  assign grant         = r_grant;
  assign busy          = (r_state != ST_IDLE);
  assign tx_done       = r_tx_done;
  assign tx_err        = r_tx_err;

endmodule

// File: tb/tb_usb_utmi_tx_arb.sv
// ----------------------------------------------------------------------------
// tb_usb_utmi_tx_arb
//   Directed bench for usb_utmi_tx_arb. A packet-level reference model tracks
//   owner / phase / remaining gap / stall run and predicts every output; a
//   compare process checks all outputs on each falling edge. Directed tests
//   add hand-computed expectations (byte order, counts, latencies).
// ----------------------------------------------------------------------------
module tb_usb_utmi_tx_arb;

  localparam int IPG = 8;
  localparam int RTO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       usb_rst = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic [7:0] utmi_data_out;
  logic       utmi_tx_valid;
  logic       utmi_tx_ready = 1'b0;
  logic       utmi_rx_active = 1'b0;
  logic [1:0] grant;
  logic       busy, tx_done, tx_err;

  always #5 clk = ~clk;

  usb_utmi_tx_arb #(.IPG_CYCLES(IPG), .READY_TIMEOUT(RTO)) dut (
    .clk            (clk),
    .rst            (rst),
    .usb_rst        (usb_rst),
    .req0_valid     (req0_valid),
    .req0_data      (req0_data),
    .req0_last      (req0_last),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_data      (req1_data),
    .req1_last      (req1_last),
    .req1_ready     (req1_ready),
    .utmi_data_out  (utmi_data_out),
    .utmi_tx_valid  (utmi_tx_valid),
    .utmi_tx_ready  (utmi_tx_ready),
    .utmi_rx_active (utmi_rx_active),
    .grant          (grant),
    .busy           (busy),
    .tx_done        (tx_done),
    .tx_err         (tx_err)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet sources ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         last0_en = 1'b0;
  bit         last1_en = 1'b0;
  int         rdy_mode = 0;   // 0: always ready, 1: every 2nd clock, 2: never
  int         cyc = 0;

  task automatic apply_src();
    req0_valid = (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    req0_last  = last0_en && (q0.size() == 1);
    req1_valid = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
    req1_last  = last1_en && (q1.size() == 1);
  endtask

  // One clock: note handshakes at the falling edge, then update the sources
  // and TxReady just after the rising edge.
  task automatic cycle();
    logic h0, h1;
    @(negedge clk);
    h0 = req0_valid & req0_ready;
    h1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (h0 && q0.size() > 0) void'(q0.pop_front());
    if (h1 && q1.size() > 0) void'(q1.pop_front());
    apply_src();
    utmi_tx_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? cyc[0] : 1'b0;
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 sending a packet, 2 inter-packet gap
  int m_phase = 0, m_owner = -1, m_gap = 0, m_stall = 0;
  bit m_done = 1'b0, m_err = 1'b0;

  always @(posedge clk or negedge rst) begin : model
    int ph, ow, gp, st;
    bit dn, er, v, l;
    if (!rst) begin
      m_phase <= 0; m_owner <= -1; m_gap <= 0; m_stall <= 0;
      m_done  <= 1'b0; m_err <= 1'b0;
    end else begin
      ph = m_phase; ow = m_owner; gp = m_gap; st = m_stall; dn = 1'b0; er = 1'b0;
      if (usb_rst) begin
        er = (ph == 1); ph = 0; ow = -1; st = 0;
      end else if (ph == 0) begin
        if (!utmi_rx_active && (req0_valid || req1_valid)) begin
          ow = req0_valid ? 0 : 1; ph = 1; st = 0;
        end
      end else if (ph == 1) begin
        v = (ow == 0) ? req0_valid : req1_valid;
        l = (ow == 0) ? req0_last  : req1_last;
        if (v && utmi_tx_ready && l) dn = 1'b1;
        else if (!v) er = 1'b1;
        else if (!utmi_tx_ready) begin
          st = st + 1;
          if (st >= RTO) er = 1'b1;
        end else st = 0;
        if (dn || er) begin ph = 2; ow = -1; gp = IPG; st = 0; end
      end else begin
        if (gp == 0) ph = 0; else gp = gp - 1;
      end
      m_phase <= ph; m_owner <= ow; m_gap <= gp; m_stall <= st;
      m_done  <= dn; m_err <= er;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("tx_valid", utmi_tx_valid, (m_phase == 1));
      check("grant", grant, (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00);
      check("busy", busy, (m_phase != 0));
      check("tx_done", tx_done, m_done);
      check("tx_err", tx_err, m_err);
      check("req0_ready", req0_ready, (m_phase == 1) && (m_owner == 0) && utmi_tx_ready);
      check("req1_ready", req1_ready, (m_phase == 1) && (m_owner == 1) && utmi_tx_ready);
      check("data_out", utmi_data_out,
            (m_owner == 0) ? req0_data : (m_owner == 1) ? req1_data : 8'h00);
    end
  end

  // ---------------- monitors for directed checks ----------------
  logic [7:0] cap[$];
  int done_cnt = 0, err_cnt = 0, r1_leak = 0, lo_run = 0, last_gap = 0;

  always @(negedge clk) begin
    if (utmi_tx_valid && utmi_tx_ready) cap.push_back(utmi_data_out);
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (grant == 2'b01 && req1_ready) r1_leak <= r1_leak + 1;
    lo_run <= utmi_tx_valid ? 0 : lo_run + 1;
    if (utmi_tx_valid && lo_run != 0) last_gap <= lo_run;
  end

  function automatic logic [8:0] cap_at(input int k);
    return (k < cap.size()) ? {1'b0, cap[k]} : 9'h1FF;
  endfunction

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin cycle(); n++; end
    check({tag, "_done_in_time"}, (n < 300), 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin cycle(); n++; end
    check({tag, "_idle_in_time"}, (n < 300), 1'b1);
  endtask

  initial begin
    int d0, e0, l0, n, hits;

    // Reset state
    #12;
    check("rst_tx_valid", utmi_tx_valid, 1'b0);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_tx_err", tx_err, 1'b0);
    cmp_en = 1'b1;
    #10 rst = 1'b1;
    repeat (2) cycle();

    // 1) req1 packet A5,3C,F0 with TxReady every 2nd clock, then a follow-up
    rdy_mode = 1; cap.delete(); d0 = done_cnt;
    q1 = '{8'hA5, 8'h3C, 8'hF0}; last1_en = 1'b1; apply_src();
    wait_done("t1", d0 + 1);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_len", cap.size(), 3);
    check("t1_b0", cap_at(0), 9'h0A5);
    check("t1_b1", cap_at(1), 9'h03C);
    check("t1_b2", cap_at(2), 9'h0F0);
    check("t1_tv_low_after_last", utmi_tx_valid, 1'b0);
    q1 = '{8'h5A}; apply_src();
    wait_done("t1b", d0 + 2);
    check("t1_gap_ge_ipg", (last_gap >= IPG), 1'b1);
    wait_idle("t1");

    // 2) both sources valid in the same idle clock: req0 first, then req1
    rdy_mode = 0; cap.delete(); d0 = done_cnt; l0 = r1_leak;
    q0 = '{8'hD2}; last0_en = 1'b1;
    q1 = '{8'h4B, 8'h7E}; last1_en = 1'b1; apply_src();
    cycle();
    check("t2_first_grant", grant, 2'b01);
    wait_done("t2", d0 + 2);
    check("t2_b0", cap_at(0), 9'h0D2);
    check("t2_b1", cap_at(1), 9'h04B);
    check("t2_b2", cap_at(2), 9'h07E);
    check("t2_req1_ready_leak", r1_leak - l0, 0);
    wait_idle("t2");

    // 3) receive in progress defers the start of a packet
    utmi_rx_active = 1'b1; d0 = done_cnt;
    q0 = '{8'hC3}; last0_en = 1'b1; apply_src();
    hits = 0;
    for (int i = 0; i < 5; i++) begin cycle(); if (utmi_tx_valid) hits++; end
    check("t3_blocked_by_rx", hits, 0);
    utmi_rx_active = 1'b0;
    check("t3_tv_still_low", utmi_tx_valid, 1'b0);
    cycle();
    check("t3_tv_up_next_edge", utmi_tx_valid, 1'b1);
    wait_done("t3", d0 + 1);
    wait_idle("t3");

    // 4) PHY never ready: abort after READY_TIMEOUT stalled SEND clocks
    rdy_mode = 2; utmi_tx_ready = 1'b0; e0 = err_cnt; n = 0; hits = 0;
    q1 = '{8'h99, 8'h98}; last1_en = 1'b1; apply_src();
    while (err_cnt == e0 && n < 200) begin cycle(); n++; if (utmi_tx_valid) hits++; end
    check("t4_err_seen", err_cnt - e0, 1);
    check("t4_send_clocks", hits, RTO);
    check("t4_tv_low", utmi_tx_valid, 1'b0);
    check("t4_grant_cleared", grant, 2'b00);
    check("t4_in_gap", busy, 1'b1);
    q1.delete(); apply_src();
    wait_idle("t4");

    // 5a) req1 underrun after 2 of 4 bytes
    rdy_mode = 0; e0 = err_cnt; d0 = done_cnt; n = 0;
    q1 = '{8'h11, 8'h22}; last1_en = 1'b0; apply_src();
    while (err_cnt == e0 && n < 50) begin cycle(); n++; end
    check("t5_underrun_err", err_cnt - e0, 1);
    check("t5_underrun_no_done", done_cnt - d0, 0);
    wait_idle("t5a");

    // 5b) USB bus reset in the middle of a req0 packet
    d0 = done_cnt;
    q0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; last0_en = 1'b1; apply_src();
    repeat (3) cycle();
    usb_rst = 1'b1; e0 = err_cnt;
    repeat (2) cycle();
    check("t5_usbrst_err", err_cnt - e0, 1);
    check("t5_usbrst_idle", busy, 1'b0);
    hits = 0;
    for (int i = 0; i < 6; i++) begin cycle(); if (grant != 2'b00) hits++; end
    check("t5_no_grant_in_usbrst", hits, 0);
    usb_rst = 1'b0;
    wait_done("t5b", d0 + 1);
    wait_idle("t5b");

    // 6) asynchronous reset while sending
    rdy_mode = 2; utmi_tx_ready = 1'b0; d0 = done_cnt;
    q1 = '{8'h77, 8'h78}; last1_en = 1'b1; apply_src();
    repeat (3) cycle();
    check("t6_sending", utmi_tx_valid, 1'b1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("t6_async_tv", utmi_tx_valid, 1'b0);
    check("t6_async_grant", grant, 2'b00);
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_ready", req1_ready, 1'b0);
    check("t6_async_data", utmi_data_out, 8'h00);
    @(negedge clk); #2;
    rst = 1'b1;
    rdy_mode = 0; utmi_tx_ready = 1'b1;
    cycle();
    wait_done("t6", d0 + 1);
    wait_idle("t6");

    repeat (3) cycle();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
